// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder using two ping-pong banks of N words.
// Optional macro CONJ_OUT_EN: output imaginary half is negated with saturation (conjugate).
module fft_bitrev_reorder #(
    parameter int N_LOG2 = 10,
    parameter int DW     = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_eof
);

    localparam int N = 1 << N_LOG2;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_t;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = a[N_LOG2-1-i];
        end
        return r;
    endfunction

    logic [DW-1:0]     mem0 [N];
    logic [DW-1:0]     mem1 [N];

    logic [N_LOG2-1:0] wcnt;
    logic              wbank;
    logic [1:0]        full;
    logic [1:0]        full_d;
    logic [N_LOG2-1:0] waddr;
    logic              wr_en;
    logic              wr_last;

    rd_state_t         state;
    rd_state_t         state_d;
    logic [N_LOG2-1:0] rcnt;
    logic [N_LOG2-1:0] rcnt_d;
    logic              rbank;
    logic              rbank_d;
    logic              rd_en;
    logic              rd_last;
    logic [DW-1:0]     rd_word;

    assign in_ready = ~full[wbank];
    assign wr_en    = in_valid & in_ready;
    assign wr_last  = wr_en & (&wcnt);
    assign waddr    = bitrev(wcnt);

    // Incoming samples land at their natural-order address, so the reader simply counts up.
    always_ff @(posedge clk) begin
        if (wr_en && !wbank) begin
            mem0[waddr] <= in_data;
        end
        if (wr_en && wbank) begin
            mem1[waddr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (wr_en) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) begin
                wbank <= ~wbank;
            end
        end
    end

    // Set and clear always target different banks, so both are applied independently.
    always_comb begin
        full_d = full;
        if (wr_last) begin
            full_d[wbank] = 1'b1;
        end
        if (rd_last) begin
            full_d[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
        end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
            rbank <= rbank_d;
        end
    end

    always_comb begin
        state_d = state;
        rcnt_d  = rcnt;
        rbank_d = rbank;
        rd_en   = 1'b0;
        rd_last = 1'b0;
        case (state)
            IDLE: begin
                if (full[rbank]) begin
                    state_d = STREAM;
                    rcnt_d  = '0;
                end
            end
            STREAM: begin
                rd_en  = 1'b1;
                rcnt_d = rcnt + 1'b1;
                if (&rcnt) begin
                    rd_last = 1'b1;
                    rbank_d = ~rbank;
                    // Staying in STREAM chains the next buffered frame without a bubble.
                    if (!full[~rbank]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word <= '0;
        end else if (rd_en) begin
            rd_word <= rbank ? mem1[rcnt] : mem0[rcnt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_sof   <= rd_en & (rcnt == '0);
            out_eof   <= rd_last;
        end
    end

`ifdef CONJ_OUT_EN
    localparam int HW = DW / 2;

    logic [HW-1:0] im_raw;
    logic [HW-1:0] im_neg;

    // The most negative value has no positive counterpart and clips to the maximum.
    assign im_raw   = rd_word[HW-1:0];
    assign im_neg   = (im_raw == {1'b1, {(HW-1){1'b0}}}) ? {1'b0, {(HW-1){1'b1}}}
                                                          : (~im_raw + 1'b1);
    assign out_data = {rd_word[DW-1:HW], im_neg};
`else
    assign out_data = rd_word;
`endif

endmodule
